jtframe_ba_arbiter: RTL
=======================

// Module: jtframe_ba_arbiter
// PURPOSE
//  Shares one SDRAM bank port (ba_rd/ba_addr/ba_ack/ba_dst/ba_dok/ba_rdy) among N game-side ROM/RAM read slots.
//  Sits between the game core's slot logic and the jtframe SDRAM controller, one instance per bank.
//  Round-robin grant, address latched at grant, per-slot routing of ack/dok/rdy, watchdog abort on a lost burst.
// PARAMETERS
//  SLOTS  4     number of requesters, 2..8
//  AW     22    SDRAM word-address width (SDRAMW)
//  TOUT   255   watchdog limit in clk cycles from ba_ack to ba_rdy, 8-bit
// PORTS
//  clk        in   1         system/SDRAM clock (clk_rom domain)
//  rst        in   1         synchronous, active-high reset
//  slot_req   in   SLOTS     level request per slot; held until that slot's slot_rdy
//  slot_addr  in   SLOTS*AW  packed addresses, slot i at [i*AW +: AW]
//  slot_ack   out  SLOTS     one-cycle pulse: the controller accepted slot i's request
//  slot_dok   out  SLOTS     data word valid for slot i (copy of ba_dok)
//  slot_rdy   out  SLOTS     one-cycle pulse: slot i's burst is complete
//  slot_dout  out  16        data bus shared by all slots (registered copy of sdram_dout)
//  ba_rd      out  1         read request to the controller
//  ba_addr    out  AW        latched address of the granted slot
//  ba_ack     in   1         controller accepted the request
//  ba_dst     in   1         first data word of the burst
//  ba_dok     in   1         data word valid
//  ba_rdy     in   1         last data word of the burst
//  sdram_dout in   16        controller read data
//  busy       out  1         high in every state except IDLE
//  tout_err   out  1         sticky; set by a watchdog abort, cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, ba_rd=0, ba_addr=0, all slot_* outputs=0, slot_dout=0, busy=0, tout_err=0.
//  FSM states IDLE -> REQ -> DATA -> IDLE.
//   IDLE
//    - If any slot_req is high, pick the first requesting slot starting at ptr, wrapping modulo SLOTS.
//    - Register gnt=i and ba_addr=slot_addr[i]; ba_rd=1 on the next cycle; go to REQ.
//    - slot_req low: stay in IDLE.
//   REQ
//    - Hold ba_rd=1 and keep ba_addr stable until ba_ack.
//    - On ba_ack: ba_rd=0; slot_ack[gnt] pulses in the same cycle (combinational from ba_ack); clear watchdog; go to DATA.
//    - Slot drops slot_req while in REQ: request still completes, nothing is cancelled.
//   DATA
//    - slot_dok[gnt]=ba_dok, combinational.
//    - slot_dout <= sdram_dout on every ba_dok, so it is valid one cycle after slot_dok.
//    - On ba_rdy: slot_rdy[gnt] pulses the same cycle; ptr <= gnt+1 (wraps SLOTS-1 -> 0); go to IDLE.
//    - Watchdog counts cycles spent in DATA. If it reaches TOUT with no ba_rdy:
//      pulse slot_rdy[gnt], set tout_err, go to IDLE, leave ptr unchanged.
//  Latency: slot_req to ba_rd = 1 cycle in IDLE. Next grant starts the cycle after ba_rdy (min 1 idle cycle between bursts).
//  Simultaneous ba_ack and ba_rdy in REQ (single-word controller): slot_ack and slot_rdy pulse together; go straight to IDLE.
//  ba_dst is used only to restart the watchdog. ba_dok/ba_rdy seen in IDLE or REQ are ignored and not routed.
//  Only slot[gnt] can see ack/dok/rdy; every other bit stays 0.
//  Reset mid-burst: state returns to IDLE. The controller completes its burst and the arbiter drops it.
//  ba_addr is never updated outside IDLE.
// CONFIGURATION
//  JTFRAME_BA_ARB_PRIO_EN
//   - Defined: fixed priority; slot 0 highest, then ascending index. ptr is held at 0.
//     Used for a CPU slot that must not wait a full rotation.
//   - Undefined: round-robin as described above.
//  Watchdog and tout_err are present in both builds.
// STRUCTURE
//  Package jtframe_ba_arb_pkg: typedef enum logic[1:0] {IDLE,REQ,DATA} arb_st_t; localparam DW=16.
//  Sub-module jtframe_rr_pick:
//   - Combinational rotate-and-priority-encode of req[SLOTS] from ptr.
//   - Outputs any and idx[$clog2(SLOTS)].
//   - Parameter FIXED selects fixed priority; the top level drives it from the macro.
//  Top level holds the FSM, ptr, gnt, address latch, watchdog and the output demux.
// TESTING
//  1. Single slot: req[2]=1, addr=22'h1234; controller acks 3 cycles later, 4 dok, rdy on last.
//     -> ba_addr=22'h1234; slot_ack[2] one pulse; 4 slot_dok[2]; slot_rdy[2] one pulse; other bits 0.
//  2. All 4 slots request continuously.
//     -> grant order 0,1,2,3,0,1; no slot granted twice before the rest are served.
//  3. Repeat test 2 with JTFRAME_BA_ARB_PRIO_EN defined.
//     -> slot 0 is granted every time it requests; slot 3 only when req[2:0]=0.
//  4. ba_ack and ba_rdy arrive in the same cycle.
//     -> slot_ack and slot_rdy pulse together; busy low on the next cycle.
//  5. TOUT=16 and the controller never asserts ba_rdy.
//     -> after 16 cycles in DATA: slot_rdy[gnt] pulses, tout_err=1, state returns to IDLE, next request served.
//  6. rst=1 for one cycle during DATA.
//     -> all outputs 0 on the next cycle; trailing ba_dok/ba_rdy cause no slot pulses.

Source files
------------

// File: rtl/jtframe_ba_arb_pkg.sv
// rtl/jtframe_ba_arb_pkg.sv - shared types and constants for the SDRAM bank-port arbiter
package jtframe_ba_arb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DATA} arb_st_t;

    localparam int DW = 16;

endpackage

// File: rtl/jtframe_rr_pick.sv
// rtl/jtframe_rr_pick.sv - rotate-and-priority-encode request picker, round-robin or fixed priority
module jtframe_rr_pick
    import jtframe_ba_arb_pkg::*;
#(
    parameter  int SLOTS = 4,
    parameter  bit FIXED = 1'b0,
    localparam int PW    = $clog2(SLOTS)
)(
    input  logic [SLOTS-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    idx
);

    function automatic logic [PW-1:0] slot_at(input int k, input logic [PW-1:0] p);
        return FIXED ? PW'(k) : PW'((int'(p) + k) % SLOTS);
    endfunction

    // Walk from the farthest candidate back to ptr so the closest requester wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (req[slot_at(k, ptr)]) begin
                any = 1'b1;
                idx = slot_at(k, ptr);
            end
        end
    end

endmodule

// File: rtl/jtframe_ba_arbiter.sv
// rtl/jtframe_ba_arbiter.sv - shares one SDRAM bank port among SLOTS read slots; JTFRAME_BA_ARB_PRIO_EN selects fixed priority
module jtframe_ba_arbiter
    import jtframe_ba_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int TOUT  = 255
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ack,
    output logic [SLOTS-1:0]    slot_dok,
    output logic [SLOTS-1:0]    slot_rdy,
    output logic [DW-1:0]       slot_dout,
    output logic                ba_rd,
    output logic [AW-1:0]       ba_addr,
    input  logic                ba_ack,
    input  logic                ba_dst,
    input  logic                ba_dok,
    input  logic                ba_rdy,
    input  logic [DW-1:0]       sdram_dout,
    output logic                busy,
    output logic                tout_err
);

    localparam int PW = $clog2(SLOTS);
`ifdef JTFRAME_BA_ARB_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam logic [7:0] WD_LAST = 8'(TOUT - 1);

    arb_st_t       st;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] gnt_next;
    logic [PW-1:0] pick_idx;
    logic          pick_any;
    logic [7:0]    wdog;
    logic          wd_expire;

    jtframe_rr_pick #(
        .SLOTS (SLOTS),
        .FIXED (FIXED)
    ) u_pick (
        .req   (slot_req),
        .ptr   (ptr),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign gnt_next  = (int'(gnt) == SLOTS - 1) ? '0 : gnt + 1'b1;
    // A ba_dst in the final cycle restarts the count instead of aborting.
    assign wd_expire = (st == DATA) && !ba_rdy && !ba_dst && (wdog == WD_LAST);
    assign busy      = (st != IDLE);

    always_comb begin
        slot_ack = '0;
        slot_dok = '0;
        slot_rdy = '0;
        case (st)
            REQ: begin
                slot_ack[gnt] = ba_ack;
                slot_rdy[gnt] = ba_ack && ba_rdy;
            end
            DATA: begin
                slot_dok[gnt] = ba_dok;
                slot_rdy[gnt] = ba_rdy || wd_expire;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            ba_rd     <= 1'b0;
            ba_addr   <= '0;
            slot_dout <= '0;
            wdog      <= '0;
            tout_err  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (pick_any) begin
                        gnt     <= pick_idx;
                        ba_addr <= slot_addr[int'(pick_idx)*AW +: AW];
                        ba_rd   <= 1'b1;
                        st      <= REQ;
                    end
                end
                REQ: begin
                    if (ba_ack) begin
                        ba_rd <= 1'b0;
                        wdog  <= '0;
                        if (ba_rdy) begin
                            st <= IDLE;
                            if (!FIXED) ptr <= gnt_next;
                        end else begin
                            st <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (ba_dok) slot_dout <= sdram_dout;
                    if (ba_rdy) begin
                        st <= IDLE;
                        if (!FIXED) ptr <= gnt_next;
                    end else if (wd_expire) begin
                        // Lost burst: release the slot but keep its turn in the rotation.
                        st       <= IDLE;
                        tout_err <= 1'b1;
                    end else if (ba_dst) begin
                        wdog <= '0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
